// File: rtl/mem_copy_engine_pkg.sv
// Shared types and helpers for the data-memory copy engine.
// Word addressing uses byte addresses whose two low bits select a byte within a word.
package mem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_LSB   = 2;
    localparam int PKG_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } copy_state_t;

    function automatic logic [PKG_ADDR_W-ADDR_LSB-1:0] word_idx(input logic [PKG_ADDR_W-1:0] addr);
        return addr[PKG_ADDR_W-1:ADDR_LSB];
    endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// Block copy master for the word-addressed data memory port: one read cycle
// followed by one write cycle per word, ascending addresses, with request validation.
module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 8,
    parameter int MEM_WORDS = 65
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
);

    copy_state_t       state_reg;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  count;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    // End-of-range sums carry one extra bit so a huge address cannot wrap into range.
    logic [ADDR_W:0] src_end;
    logic [ADDR_W:0] dst_end;
    logic            misaligned;
    logic            out_of_range;
    logic            reject;

    assign src_end      = (ADDR_W+1)'(word_idx(src_addr)) + (ADDR_W+1)'(len);
    assign dst_end      = (ADDR_W+1)'(word_idx(dst_addr)) + (ADDR_W+1)'(len);
    assign misaligned   = (src_addr[ADDR_LSB-1:0] != '0) || (dst_addr[ADDR_LSB-1:0] != '0);
    assign out_of_range = (src_end > (ADDR_W+1)'(MEM_WORDS)) || (dst_end > (ADDR_W+1)'(MEM_WORDS));
    assign reject       = misaligned || out_of_range;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            count     <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    err_q <= 1'b0;
                    if (start) begin
                        src_ptr <= src_addr;
                        dst_ptr <= dst_addr;
                        count   <= len;
                        if (reject) begin
                            err_q     <= 1'b1;
                            state_reg <= FINISH;
                        end else if (len == '0) begin
                            state_reg <= FINISH;
                        end else begin
                            state_reg <= READ;
                        end
                    end
                end
                READ: begin
                    data_q    <= mem_rd;
                    state_reg <= WRITE;
                end
                WRITE: begin
                    src_ptr <= src_ptr + ADDR_W'(WORD_BYTES);
                    dst_ptr <= dst_ptr + ADDR_W'(WORD_BYTES);
                    count   <= count - LEN_W'(1);
                    if (count == LEN_W'(1)) begin
                        state_reg <= FINISH;
                    end else begin
                        state_reg <= READ;
                    end
                end
                FINISH: begin
                    err_q     <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Moore decode; the address bus idles at zero outside the two access states.
    always_comb begin
        busy   = (state_reg != IDLE);
        done   = (state_reg == FINISH);
        err    = (state_reg == FINISH) && err_q;
        mem_we = (state_reg == WRITE);
        mem_wd = data_q;
        mem_a  = '0;
        if (state_reg == READ) begin
            mem_a = src_ptr;
        end else if (state_reg == WRITE) begin
            mem_a = dst_ptr;
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: behavioural data memory as responder,
// expected writes and completions queued by stimulus, checked by a monitor.
module tb_mem_copy_engine;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int LEN_W     = 8;
    localparam int MEM_WORDS = 65;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rd;

    mem_copy_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .err(err),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write commits on the falling edge.
    logic [DATA_W-1:0] ram [0:MEM_WORDS-1];
    always_comb begin
        mem_rd = '0;
        if (mem_a[ADDR_W-1:2] < MEM_WORDS) mem_rd = ram[mem_a[ADDR_W-1:2]];
    end
    always @(negedge clk) begin
        if (mem_we && mem_a[ADDR_W-1:2] < MEM_WORDS) ram[mem_a[ADDR_W-1:2]] <= mem_wd;
    end

    typedef struct {
        logic [31:0] word;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic err;
        int   lat;
        int   nwr;
    } op_t;

    wr_t wq[$];
    op_t eq[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expected writes on every mem_we and expected results on every done.
    int   acc_cyc = 0;
    int   we_cnt  = 0;
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            busy_prev = 1'b0;
        end else begin
            if (busy && !busy_prev) begin
                acc_cyc = cyc;
                we_cnt  = 0;
            end
            if (mem_we) begin
                we_cnt++;
                if (wq.size() == 0) begin
                    check("unexpected_write", {32'h0, mem_a}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("write_addr", {32'h0, mem_a}, {32'h0, w.word << 2});
                    check("write_data", {32'h0, mem_wd}, {32'h0, w.data});
                    $display("write word %0d data 0x%08h", mem_a[ADDR_W-1:2], mem_wd);
                end
            end
            if (done) begin
                done_cnt++;
                if (eq.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    op_t e;
                    e = eq.pop_front();
                    check("done_err", {63'h0, err}, {63'h0, e.err});
                    check("done_latency", 64'(cyc - acc_cyc + 1), 64'(e.lat));
                    check("write_count", 64'(we_cnt), 64'(e.nwr));
                    $display("done err=%0b latency=%0d writes=%0d", err, cyc - acc_cyc + 1, we_cnt);
                end
            end
            busy_prev = busy;
        end
    end

    task automatic push_op(input logic e_err, input int lat, input int nwr);
        op_t o;
        o.err = e_err; o.lat = lat; o.nwr = nwr;
        eq.push_back(o);
    endtask

    task automatic push_wr(input logic [31:0] word, input logic [31:0] data);
        wr_t w;
        w.word = word; w.data = data;
        wq.push_back(w);
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (done_cnt < target && k < 600) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt < target) check("done_timeout", 64'(done_cnt), 64'(target));
        repeat (2) @(negedge clk);
    endtask

    task automatic run_op(input logic [31:0] s, input logic [31:0] d, input logic [7:0] l);
        int target;
        target = done_cnt + 1;
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(target);
    endtask

    initial begin
        int target;
        rst = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        for (int i = 0; i < MEM_WORDS; i++) ram[i] = 32'hC0DE_0000 | i;
        ram[0] = 32'hAAAA_0001; ram[1] = 32'hBBBB_0002;
        ram[2] = 32'hCCCC_0003; ram[3] = 32'hDDDD_0004;
        repeat (3) @(negedge clk);
        check("reset_busy",   {63'h0, busy},   64'd0);
        check("reset_done",   {63'h0, done},   64'd0);
        check("reset_err",    {63'h0, err},    64'd0);
        check("reset_we",     {63'h0, mem_we}, 64'd0);
        check("reset_mem_a",  {32'h0, mem_a},  64'd0);
        check("reset_mem_wd", {32'h0, mem_wd}, 64'd0);
        rst = 1'b1;

        // Plain 4-word copy.
        push_wr(16, 32'hAAAA_0001); push_wr(17, 32'hBBBB_0002);
        push_wr(18, 32'hCCCC_0003); push_wr(19, 32'hDDDD_0004);
        push_op(1'b0, 9, 4);
        run_op(32'h0, 32'h40, 8'd4);
        check("ram16", {32'h0, ram[16]}, {32'h0, 32'hAAAA_0001});
        check("ram19", {32'h0, ram[19]}, {32'h0, 32'hDDDD_0004});

        // Zero length: immediate completion, no access.
        push_op(1'b0, 1, 0);
        run_op(32'h0, 32'h10, 8'd0);
        check("len0_ram4", {32'h0, ram[4]}, {32'h0, 32'hC0DE_0004});

        // Misaligned source.
        push_op(1'b1, 1, 0);
        run_op(32'h2, 32'h40, 8'd1);
        check("misalign_ram16", {32'h0, ram[16]}, {32'h0, 32'hAAAA_0001});

        // Range boundary on the source: word 64 + 2 exceeds 65, + 1 does not.
        push_op(1'b1, 1, 0);
        run_op(32'h100, 32'h80, 8'd2);
        push_wr(32, 32'hC0DE_0040);
        push_op(1'b0, 3, 1);
        run_op(32'h100, 32'h80, 8'd1);
        check("range_ram32", {32'h0, ram[32]}, {32'h0, 32'hC0DE_0040});

        // Destination range and maximum length rejected.
        push_op(1'b1, 1, 0);
        run_op(32'h0, 32'hFC, 8'd3);
        push_op(1'b1, 1, 0);
        run_op(32'h0, 32'h0, 8'd255);

        // Overlapping forward copy with ignored starts while busy.
        ram[0] = 32'h1111_1111; ram[1] = 32'h2222_2222; ram[2] = 32'h3333_3333;
        push_wr(1, 32'h1111_1111); push_wr(2, 32'h1111_1111);
        push_op(1'b0, 5, 2);
        target = done_cnt + 1;
        @(negedge clk);
        src_addr = 32'h0; dst_addr = 32'h4; len = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        src_addr = 32'h0; dst_addr = 32'h80; len = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(target);
        repeat (4) @(negedge clk);
        check("overlap_one_done", 64'(done_cnt), 64'(target));
        check("overlap_ram1", {32'h0, ram[1]}, {32'h0, 32'h1111_1111});
        check("overlap_ram2", {32'h0, ram[2]}, {32'h0, 32'h1111_1111});

        // Reset during cycle T0+3 of a 4-word copy: only the first word lands.
        push_wr(24, 32'hC0DE_0008);
        @(negedge clk);
        src_addr = 32'h20; dst_addr = 32'h60; len = 8'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_busy", {63'h0, busy},   64'd0);
        check("midreset_we",   {63'h0, mem_we}, 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset_ram24", {32'h0, ram[24]}, {32'h0, 32'hC0DE_0008});
        check("midreset_ram25", {32'h0, ram[25]}, {32'h0, 32'hC0DE_0019});

        // Normal operation after reset.
        push_wr(24, 32'hC0DE_0008); push_wr(25, 32'hC0DE_0009);
        push_op(1'b0, 5, 2);
        run_op(32'h20, 32'h60, 8'd2);
        check("post_ram25", {32'h0, ram[25]}, {32'h0, 32'hC0DE_0009});

        check("writes_left", 64'(wq.size()), 64'd0);
        check("ops_left",    64'(eq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator-side master for the word-addressed data memory port (a, wd, we, rd): copies a block of 32-bit words from a source byte address to a destination byte address.
- Sits beside the core on the data-memory bus, which it owns while busy. The core arbiter selects its mem_* outputs whenever busy=1.
- Drives the memory exactly as the memory expects:
  - read data returns combinationally from the address in the same cycle;
  - writes commit on the falling edge of the cycle in which we=1.

Parameters:
- DATA_W, 32, memory data width in bits.
- ADDR_W, 32, byte-address width; memory word index is addr[ADDR_W-1:2].
- LEN_W, 8, width of the word-count input.
- MEM_WORDS, 65, number of valid memory words; used for range checking.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- src_addr  in  ADDR_W  source byte address; must be word-aligned.
- dst_addr  in  ADDR_W  destination byte address; must be word-aligned.
- len  in  LEN_W  number of words to copy.
- busy  out  1  high from accept until done, inclusive.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, when a request is rejected.
- mem_a  out  ADDR_W  byte address to the data memory.
- mem_wd  out  DATA_W  write data to the data memory.
- mem_we  out  1  write enable to the data memory.
- mem_rd  in  DATA_W  read data from the data memory; combinational from mem_a.

Behaviour:
- FSM states: IDLE, READ, WRITE, FINISH. All outputs are Moore, decoded from registered state and datapath registers.
- Reset (rst=0 at a rising edge):
  - state=IDLE; src_ptr, dst_ptr, count and data_q are cleared to 0;
  - busy=0, done=0, err=0, mem_we=0, mem_a=0, mem_wd=0.
  - Reset mid-copy abandons the copy. Words already written stay written. No write occurs in the cycle after reset.
- IDLE:
  - busy=0, mem_we=0.
  - On start=1, latch src_addr, dst_addr and len.
  - Reject the request (err_q=1, go to FINISH) if any of these hold:
    - src_addr[1:0]!=0;
    - dst_addr[1:0]!=0;
    - src_addr[ADDR_W-1:2]+len > MEM_WORDS, computed at ADDR_W+1 bits with no wrap;
    - dst_addr[ADDR_W-1:2]+len > MEM_WORDS, computed the same way.
  - Otherwise, if len=0, go to FINISH with err_q=0 and perform no memory access.
  - Otherwise go to READ.
- READ:
  - mem_a=src_ptr, mem_we=0.
  - At the rising edge: data_q<=mem_rd, then go to WRITE.
- WRITE:
  - mem_a=dst_ptr, mem_wd=data_q, mem_we=1.
  - At the rising edge: src_ptr+=4, dst_ptr+=4, count-=1.
  - If count was 1, go to FINISH; otherwise go to READ.
- FINISH: done=1, err=err_q, busy=1; next state IDLE, where err_q is cleared.
- busy=1 in READ, WRITE and FINISH.
- start while busy is ignored and not queued.
- Latency: start accepted at edge T0 → done high in cycle T0+2*len+1. A rejected or zero-length request gives done in cycle T0+1.
- Throughput: 2 cycles per word. A new start is accepted only in the IDLE cycle that follows FINISH.
- Overlap: the copy always runs in ascending address order.
  - If dst>src and the ranges overlap, already-copied words are re-read. This is the defined behaviour, not an error.
  - src==dst is legal and rewrites identical data.
- Width rules:
  - Pointers are ADDR_W bits; increments cannot overflow because of the range check.
  - count is LEN_W bits; len = 2^LEN_W-1 is legal if it is in range.
- mem_wd holds data_q in every state. Only mem_we qualifies a write.

Decomposition:
- Shared package mem_pkg:
  - copy_state_t enum {IDLE, READ, WRITE, FINISH};
  - localparams WORD_BYTES=4 and ADDR_LSB=2;
  - function word_idx(addr), returning addr[ADDR_W-1:2].
- No sub-module. FSM and datapath live in one module.
- The bench instantiates the existing data memory as the responder.

Test Plan:
- Preload RAM[0..3]={A,B,C,D}; start with src=0x0, dst=0x40, len=4 → RAM[16..19]={A,B,C,D}; mem_we high on exactly 4 cycles; done in cycle T0+9; err=0.
- len=0, src=0x0, dst=0x10 → done=1 in cycle T0+1; mem_we never asserted; RAM unchanged.
- src=0x2 (misaligned), len=1 → done=1 and err=1 in cycle T0+1; no writes.
- Range: src=0x100 (word 64), len=2, MEM_WORDS=65 → err=1. Same request with len=1 → copies RAM[64] to dst; err=0.
- Overlap: RAM[0..2]={X,Y,Z}; src=0x0, dst=0x4, len=2 → RAM[1]=X, RAM[2]=X; start pulses while busy are ignored, with exactly one done.
- Reset: deassert rst (drive 0) in cycle T0+3 of a len=4 copy → next cycle busy=0, mem_we=0; only RAM[dst word 0] is updated; a following start runs normally.
